// File: rtl/led_sequencer.sv
// led_sequencer: button-cycled LED pattern modes stepped by a divided tick, with hold and PWM dimming
module led_sequencer #(
  parameter int unsigned TICK_DIV = 1500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn,
  input  logic       hold,
  input  logic [3:0] brightness,
  output logic [7:0] LPORT
);
  typedef enum logic [1:0] {ALL_ON, COUNT, BOUNCE, BLINK} mode_t;
  localparam logic [23:0] TMAX = 24'(TICK_DIV - 1);
  mode_t mode, mode_nxt;
  logic [23:0] tcnt;
  logic [7:0] pattern, pattern_nxt;
  logic [3:0] pwm_cnt;
  logic tick, btn_s1, btn_s2, btn_q, press, dir, dir_nxt, en;
  assign tick = tcnt == TMAX;
  // the button is only looked at on tick cycles, which also debounces it
  assign press = tick & btn_s2 & ~btn_q;
  assign en = (brightness == 4'hF) | (pwm_cnt < brightness);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tcnt    <= '0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_q   <= 1'b0;
      pwm_cnt <= '0;
      LPORT   <= '0;
    end else begin
      tcnt    <= tick ? '0 : tcnt + 24'd1;
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
      if (tick) btn_q <= btn_s2;
      pwm_cnt <= pwm_cnt + 4'd1;
      LPORT   <= pattern & {8{en}};
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mode    <= ALL_ON;
      pattern <= 8'hFF;
      dir     <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      pattern <= pattern_nxt;
      dir     <= dir_nxt;
    end
  // dir: 0 = moving left (toward bit 7), 1 = moving right
  always_comb begin
    mode_nxt    = mode;
    pattern_nxt = pattern;
    dir_nxt     = dir;
    if (press) begin
      mode_nxt    = mode_t'(mode + 2'd1);
      pattern_nxt = mode_nxt == COUNT ? 8'h00 : mode_nxt == BOUNCE ? 8'h01 : 8'hFF;
      dir_nxt     = 1'b0;
    end else if (tick && !hold) begin
      if (mode == COUNT) pattern_nxt = pattern + 8'd1;
      else if (mode == BLINK) pattern_nxt = ~pattern;
      else if (mode == BOUNCE) begin
        if (!dir) begin
          pattern_nxt = pattern == 8'h80 ? 8'h40 : {pattern[6:0], 1'b0};
          dir_nxt     = pattern == 8'h80;
        end else begin
          pattern_nxt = pattern == 8'h01 ? 8'h02 : {1'b0, pattern[7:1]};
          dir_nxt     = pattern != 8'h01;
        end
      end
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: table and directed checks of led_sequencer with TICK_DIV=4, expectations queued then popped on observation
module tb_led_sequencer;
  logic clk = 1'b0, rstn = 1'b0, btn = 1'b0, hold = 1'b0;
  logic [3:0] brightness = 4'hF;
  logic [7:0] LPORT;
  int errs = 0, checks = 0, ec = 0;
  logic [7:0] exp_q[$];
  logic [7:0] bseq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  typedef struct { int presses; logic [31:0] seq; } vec_t;
  vec_t vecs [5];
  led_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .btn(btn), .hold(hold), .brightness(brightness), .LPORT(LPORT)
  );
  always #5 clk = ~clk;
  // edges since reset release; with TICK_DIV=4 every edge where ec becomes a multiple of 4 is a tick
  always @(posedge clk or negedge rstn)
    if (!rstn) ec <= 0;
    else ec <= ec + 1;
  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: LPORT=%02h expected %02h (t=%0t)", nm, got, want, $time);
    end
  endtask
  task automatic chk_i(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask
  task automatic pop_chk(input string nm);
    if (exp_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s: no expected value queued, LPORT=%02h", nm, LPORT);
    end else chk8(nm, LPORT, exp_q.pop_front());
  endtask
  task automatic to_tick();
    do begin @(posedge clk); #1; end while (ec % 4 != 0);
  endtask
  task automatic obs(input string nm);
    @(posedge clk); #1;
    pop_chk(nm);
    to_tick();
  endtask
  task automatic edge_chk(input string nm, input logic [7:0] v);
    exp_q.push_back(v);
    @(posedge clk); #1;
    pop_chk(nm);
  endtask
  task automatic press();
    to_tick();
    btn = 1'b1;
    to_tick();
    btn = 1'b0;
  endtask
  task automatic do_reset();
    btn = 1'b0;
    hold = 1'b0;
    exp_q.delete();
    #2 rstn = 1'b0;
    #1 chk8("reset_async", LPORT, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk8("reset_held", LPORT, 8'h00);
    @(negedge clk) rstn = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end
  initial begin
    int lit, dark;
    vecs[0] = '{presses: 0, seq: 32'hFFFFFFFF};
    vecs[1] = '{presses: 1, seq: 32'h00010203};
    vecs[2] = '{presses: 2, seq: 32'h01020408};
    vecs[3] = '{presses: 3, seq: 32'hFF00FF00};
    vecs[4] = '{presses: 4, seq: 32'hFFFFFFFF};
    do_reset();
    edge_chk("reset_first_edge", 8'hFF);
    for (int i = 0; i < 80; i++) edge_chk("all_on_steady", 8'hFF);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      repeat (vecs[i].presses) press();
      for (int j = 3; j >= 0; j--) exp_q.push_back(vecs[i].seq[j*8 +: 8]);
      repeat (4) obs($sformatf("mode_after_%0d_presses", vecs[i].presses));
    end
    do_reset();
    press();
    for (int i = 0; i <= 256; i++) exp_q.push_back(8'(i));
    repeat (257) obs("count_wrap");
    do_reset();
    press();
    press();
    for (int i = 0; i < 16; i++) exp_q.push_back(bseq[i]);
    repeat (16) obs("bounce_seq");
    brightness = 4'd4;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      lit = 0;
      dark = 0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        if (LPORT === 8'hFF) lit++;
        else if (LPORT === 8'h00) dark++;
      end
      chk_i("pwm4_lit_cycles", lit, 4);
      chk_i("pwm4_dark_cycles", dark, 12);
    end
    brightness = 4'hF;
    edge_chk("bright_next_clk", 8'hFF);
    brightness = 4'h0;
    edge_chk("dim_next_clk", 8'h00);
    dark = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (LPORT === 8'h00) dark++;
    end
    chk_i("pwm0_dark_cycles", dark, 16);
    brightness = 4'hF;
    do_reset();
    to_tick();
    btn = 1'b1;
    @(posedge clk); #1;
    btn = 1'b0;
    repeat (3) exp_q.push_back(8'hFF);
    repeat (3) obs("glitch_ignored");
    press();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    repeat (2) obs("glitch_then_press");
    do_reset();
    btn = 1'b1;
    repeat (10) to_tick();
    btn = 1'b0;
    press();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    repeat (2) obs("held_btn_one_advance");
    do_reset();
    press();
    hold = 1'b1;
    press();
    repeat (4) exp_q.push_back(8'h01);
    repeat (4) obs("press_under_hold");
    hold = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    repeat (3) obs("hold_released");
    do_reset();
    press();
    press();
    for (int i = 0; i < 4; i++) exp_q.push_back(bseq[i]);
    repeat (4) obs("bounce_before_reset");
    edge_chk("bounce_at_10", 8'h10);
    #2 rstn = 1'b0;
    #1 chk8("midrun_reset_async", LPORT, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    edge_chk("midrun_first_edge", 8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    repeat (2) obs("midrun_all_on");
    press();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    repeat (2) obs("midrun_next_is_count");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1500000, giving clk cycles per pattern step (8 Hz at 12 MHz); legal range 2..2^24.
REQ-002 The block SHALL have port clk, input, 1, the single system clock (12 MHz on board).
REQ-003 The block SHALL have port rstn, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port btn, input, 1, the mode-advance pushbutton; it is asynchronous and bouncy, active-high.
REQ-005 The block SHALL have port hold, input, 1, which freezes pattern stepping while high; it is synchronous to clk.
REQ-006 The block SHALL have port brightness, input, 4, the PWM duty: 0 = off, 15 = always on.
REQ-007 The block SHALL have port LPORT, output, 8, the registered LED drive; 1 = LED lit.
REQ-008 Clocking: one clock, clk; all state SHALL update on its rising edge. Reset SHALL be rstn, asynchronous assert, active-low.

Function
REQ-009 Tick: the counter SHALL count 0..TICK_DIV-1 and wrap to 0. The tick pulse SHALL be high for exactly one cycle when the counter equals TICK_DIV-1. The counter SHALL free-run regardless of hold.
REQ-010 btn SHALL pass through a 2-flop synchronizer. The synced value SHALL be sampled only on tick cycles into btn_q.
REQ-011 A press SHALL be detected on a tick where the synced btn is 1 and btn_q is 0. Glitches not present at a tick sample are thereby ignored.
REQ-012 The mode FSM SHALL have states ALL_ON -> COUNT -> BOUNCE -> BLINK -> ALL_ON. It SHALL advance one state per detected press and is unaffected by hold.
REQ-013 On a press, the pattern SHALL load the entry value of the new mode in that same tick cycle, with no step:
  - ALL_ON: 8'hFF
  - COUNT: 8'h00
  - BOUNCE: 8'h01, dir = left
  - BLINK: 8'hFF
REQ-014 On a tick with no press and hold=0, the pattern SHALL step:
  - ALL_ON: unchanged
  - COUNT: +1 mod 256 (8'hFF -> 8'h00)
  - BLINK: bitwise invert
REQ-015 BOUNCE stepping (one-hot):
  - dir=left: shift left; at 8'h80 the next value is 8'h40 and dir becomes right.
  - dir=right: shift right; at 8'h01 the next value is 8'h02 and dir becomes left.
  - Sequence: 01,02,..,80,40,..,01,02,...
REQ-016 A press SHALL take priority over hold. A mode change under hold loads the entry value, then holds it.
REQ-017 PWM: a 4-bit counter pwm_cnt SHALL increment every clk and wrap 15->0. en = (brightness==15) | (pwm_cnt < brightness).
REQ-018 LPORT SHALL be registered as pattern & {8{en}}, one cycle after the pattern and pwm_cnt values it reflects.
REQ-019 A brightness change SHALL take effect on the next clk. No pattern or mode state depends on brightness.

Reset
REQ-020 While rstn=0 the block SHALL immediately hold:
  - LPORT=8'h00
  - mode=ALL_ON, pattern=8'hFF, dir=left
  - tick counter=0, pwm_cnt=0, synchronizer flops=0, btn_q=0
REQ-021 Reset mid-operation SHALL abandon the current mode and pattern with no residual state. The first LPORT update SHALL occur on the first clk edge after rstn rises.

Verification (TICK_DIV=4 for simulation)
REQ-022 Reset, hold rstn=0 with brightness=15 -> LPORT=00 during reset; after release LPORT=FF from the 1st edge onward, constant across 20 ticks.
REQ-023 Count wrap, one press then run 256 ticks (brightness=15) -> LPORT steps 00,01,..,FF,00.
REQ-024 Bounce reversal, two presses then 16 ticks -> LPORT sequence 01,02,04,..,80,40,20,..,01,02.
REQ-025 PWM, ALL_ON with brightness=4 -> LPORT=FF for exactly 4 of every 16 consecutive clk cycles and 00 otherwise; brightness=0 -> LPORT constantly 00.
REQ-026 Button filtering:
  - a 1-cycle btn pulse between ticks -> no mode change
  - btn held high across 10 ticks -> exactly one advance
  - press with hold=1 in COUNT -> BOUNCE entry 01, frozen until hold=0.
REQ-027 Mid-run reset, in BOUNCE at pattern 8'h10, assert rstn=0 asynchronously between edges -> LPORT=00 without a clock edge; after release, mode=ALL_ON and LPORT=FF.
